// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back controller.
//   XLEN_DEFAULT : default result / register data width
//   REG_AW, NREG : register address width and register count
//   wb_src_e     : which producer owns the write port in a given cycle
package wb_pkg;
  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_AW       = 5;
  localparam int unsigned NREG         = 32;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding MEM results awaiting a write-port slot.
//   clk, reset : clock, synchronous active-high reset (discards contents)
//   push/wdata : enqueue (ignored when full)
//   pop/rdata  : dequeue (ignored when empty); rdata shows the head
//   count      : occupancy 0..DEPTH; full/empty flags
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the CPU register file; sole owner of rf_we/rf_rd/rf_wd.
// Merges single-cycle ALU results (priority, bounded by a starvation limit) with
// queued MEM results, registers the winning write, and keeps a per-register busy
// scoreboard for decode hazard stalls.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   issue_valid/issue_rd  : destination of an issued instruction (sets busy)
//   alu_valid/ready/rd/data : ALU result handshake (ready = ALU selected)
//   mem_valid/ready/rd/data : MEM result handshake into the queue (ready = !full)
//   rf_we/rf_rd/rf_wd     : registered regfile write port
//   rs1/rs2, rs1_busy/rs2_busy : decode operands and their pending-write flags
//   mq_count              : MEM queue occupancy
// Optional feature macro WB_BYPASS_EN adds rsN_fwd_hit/rsN_fwd_data, forwarding
// the write-port data to decode during the commit cycle.
module regfile_wb_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned MQ_DEPTH   = 4,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_AW-1:0]         alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [XLEN-1:0]           mem_data,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_rd,
  output logic [XLEN-1:0]           rf_wd,
  input  logic [REG_AW-1:0]         rs1,
  input  logic [REG_AW-1:0]         rs2,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [$clog2(MQ_DEPTH):0] mq_count
`ifdef WB_BYPASS_EN
  ,
  output logic                      rs1_fwd_hit,
  output logic [XLEN-1:0]           rs1_fwd_data,
  output logic                      rs2_fwd_hit,
  output logic [XLEN-1:0]           rs2_fwd_data
`endif
);
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  logic                     mq_full, mq_empty, mq_pop, mq_push;
  logic [REG_AW+XLEN-1:0]   mq_head;
  logic [SW-1:0]            starve_cnt;
  wb_src_e                  sel;
  logic                     sel_we;
  logic [REG_AW-1:0]        sel_rd;
  logic [XLEN-1:0]          sel_data;
  logic [NREG-1:0]          busy, busy_nxt;

  assign mem_ready = !mq_full;
  assign mq_push   = mem_valid && !mq_full;

  wb_fifo #(
    .DEPTH (MQ_DEPTH),
    .WIDTH (REG_AW + XLEN)
  ) u_mq (
    .clk   (clk),
    .reset (reset),
    .push  (mq_push),
    .wdata ({mem_rd, mem_data}),
    .pop   (mq_pop),
    .rdata (mq_head),
    .count (mq_count),
    .full  (mq_full),
    .empty (mq_empty)
  );

  always_comb begin
    sel      = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (alu_valid && (mq_empty || starve_cnt < SW'(STARVE_LIM))) begin
      sel      = SRC_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (!mq_empty) begin
      sel      = SRC_MEM;
      sel_rd   = mq_head[XLEN +: REG_AW];
      sel_data = mq_head[XLEN-1:0];
    end
    // x0 results are consumed like any other but never reach the write port.
    sel_we    = (sel != SRC_NONE) && (sel_rd != '0);
    alu_ready = (sel == SRC_ALU);
    mq_pop    = (sel == SRC_MEM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wd      <= '0;
      starve_cnt <= '0;
    end else begin
      rf_we <= sel_we;
      if (sel != SRC_NONE) begin
        rf_rd <= sel_rd;
        rf_wd <= sel_data;
      end
      if (mq_pop || mq_empty)  starve_cnt <= '0;
      else if (sel == SRC_ALU) starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Commit clears, then a same-cycle issue re-sets: set wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_we)       busy_nxt[rf_rd]    = 1'b0;
    if (issue_valid) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

`ifdef WB_BYPASS_EN
  // reissued[r]: an issue to r arrived at or after the cycle r's in-flight
  // result was selected, so that younger write is still outstanding when the
  // forwarded value commits and must keep the stall.
  logic [NREG-1:0] reissued, reissued_nxt;

  always_comb begin
    reissued_nxt = reissued;
    if (sel_we)      reissued_nxt[sel_rd]   = 1'b0;
    if (issue_valid) reissued_nxt[issue_rd] = 1'b1;
    reissued_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) reissued <= '0;
    else       reissued <= reissued_nxt;
  end

  assign rs1_fwd_hit  = rf_we && (rf_rd == rs1) && (rs1 != '0);
  assign rs2_fwd_hit  = rf_we && (rf_rd == rs2) && (rs2 != '0);
  assign rs1_fwd_data = rf_wd;
  assign rs2_fwd_data = rf_wd;
  assign rs1_busy = rs1_fwd_hit ? (busy[rs1] && reissued[rs1]) : busy[rs1];
  assign rs2_busy = rs2_fwd_hit ? (busy[rs2] && reissued[rs2]) : busy[rs2];
`else
  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int SLIM = 3;

  logic clk, reset;
  logic issue_valid;            logic [4:0] issue_rd;
  logic alu_valid, alu_ready;   logic [4:0] alu_rd;  logic [XLEN-1:0] alu_data;
  logic mem_valid, mem_ready;   logic [4:0] mem_rd;  logic [XLEN-1:0] mem_data;
  logic rf_we;                  logic [4:0] rf_rd;   logic [XLEN-1:0] rf_wd;
  logic [4:0] rs1, rs2;
  logic rs1_busy, rs2_busy;
  logic [2:0] mq_count;
`ifdef WB_BYPASS_EN
  logic rs1_fwd_hit, rs2_fwd_hit;
  logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

  regfile_wb_ctrl #(.XLEN(XLEN), .MQ_DEPTH(DEPTH), .STARVE_LIM(SLIM)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .mq_count(mq_count)
`ifdef WB_BYPASS_EN
    , .rs1_fwd_hit(rs1_fwd_hit), .rs1_fwd_data(rs1_fwd_data)
    , .rs2_fwd_hit(rs2_fwd_hit), .rs2_fwd_data(rs2_fwd_data)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: result queue, pending-write set, last issue time per register.
  typedef struct { logic [4:0] rd; logic [XLEN-1:0] d; } ent_t;
  ent_t q[$];
  int starve, cyc, m_sel_cyc;
  logic m_we; logic [4:0] m_rd; logic [XLEN-1:0] m_wd;
  bit m_busy[32];
  int last_iss[32];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_busy(input logic [4:0] r);
    if (r == 0) return 0;
`ifdef WB_BYPASS_EN
    if (m_we && m_rd == r) return m_busy[r] && (last_iss[r] >= m_sel_cyc);
`endif
    return m_busy[r];
  endfunction

  task automatic model_reset();
    q.delete(); starve = 0; m_we = 0; m_rd = 0; m_wd = 0;
    foreach (m_busy[i]) begin m_busy[i] = 0; last_iss[i] = -1; end
  endtask

  task automatic idle();
    issue_valid = 0; alu_valid = 0; mem_valid = 0;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one clock.
  task automatic step();
    bit sa, sm, can_push;
    logic n_we; logic [4:0] n_rd; logic [XLEN-1:0] n_wd;
    #1;
    sa = alu_valid && (q.size() == 0 || starve < SLIM);
    sm = !sa && q.size() > 0;
    chk("alu_ready", alu_ready, sa);
    chk("mem_ready", mem_ready, q.size() < DEPTH);
    chk("mq_count", mq_count, q.size());
    chk("rf_we", rf_we, m_we);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_wd", rf_wd, m_wd);
    chk("rs1_busy", rs1_busy, exp_busy(rs1));
    chk("rs2_busy", rs2_busy, exp_busy(rs2));
`ifdef WB_BYPASS_EN
    chk("rs1_fwd_hit", rs1_fwd_hit, m_we && m_rd == rs1 && rs1 != 0);
    chk("rs2_fwd_hit", rs2_fwd_hit, m_we && m_rd == rs2 && rs2 != 0);
    if (m_we) chk("fwd_data", rs1_fwd_data, m_wd);
`endif
    @(posedge clk);
    if (reset) model_reset();
    else begin
      n_we = 0; n_rd = m_rd; n_wd = m_wd;
      if (sa) begin
        n_we = (alu_rd != 0); n_rd = alu_rd; n_wd = alu_data; m_sel_cyc = cyc;
      end else if (sm) begin
        n_we = (q[0].rd != 0); n_rd = q[0].rd; n_wd = q[0].d; m_sel_cyc = cyc;
      end
      if (m_we) m_busy[m_rd] = 0;
      if (issue_valid && issue_rd != 0) begin m_busy[issue_rd] = 1; last_iss[issue_rd] = cyc; end
      if (sm || q.size() == 0) starve = 0;
      else if (sa) starve++;
      can_push = q.size() < DEPTH;
      if (sm) void'(q.pop_front());
      if (mem_valid && can_push) q.push_back('{rd: mem_rd, d: mem_data});
      m_we = n_we; m_rd = n_rd; m_wd = n_wd;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int n;
    cyc = 0; m_sel_cyc = 0;
    idle(); reset = 1; rs1 = 0; rs2 = 0;
    issue_rd = 0; alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    step();                                   // reset values
    chk("rst_mq_count", mq_count, 0);
    chk("rst_rf_we", rf_we, 0);
    reset = 0;

    // 1. ALU write to x5, busy until commit
    issue_valid = 1; issue_rd = 5; rs1 = 5; step();
    idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF; step();
    idle();
    chk("t1_we", rf_we, 1); chk("t1_rd", rf_rd, 5); chk("t1_wd", rf_wd, 32'hDEADBEEF);
    step();
    chk("t1_busy_clear", rs1_busy, 0);

    // 2. ALU / MEM collision
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h44; step();
    idle();
    chk("t2_first", rf_rd, 3); chk("t2_cnt1", mq_count, 1);
    step();
    chk("t2_second", rf_rd, 4); chk("t2_wd", rf_wd, 32'h44); chk("t2_cnt0", mq_count, 0);

    // 3. Starvation limit
    mem_valid = 1; mem_rd = 7; mem_data = 32'h77; step();
    idle(); alu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alu_rd = 5'(10 + i); alu_data = 32'(i); #1;
      chk("t3_alu_win", alu_ready, 1); step();
    end
    alu_rd = 13; #1; chk("t3_starved", alu_ready, 0); step();
    chk("t3_mem_rd", rf_rd, 7);

    // 4. Full queue under continuous ALU traffic; held MEM item not lost
    n = 0; alu_valid = 1; mem_valid = 1;
    for (int i = 0; i < 10; i++) begin
      alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom;
      mem_rd = 5'(16 + n); mem_data = 32'(n);
      #1;
      if (q.size() == DEPTH) begin chk("t4_full_rdy", mem_ready, 0); chk("t4_full_cnt", mq_count, 4); end
      if (q.size() < DEPTH) n++;
      step();
    end
    idle();
    for (int i = 0; i < 8 && q.size() > 0; i++) step();
    chk("t4_drained", mq_count, 0);

    // 5. x0 result and reset with queued results
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF; #1;
    chk("t5_x0_ready", alu_ready, 1); step();
    idle(); chk("t5_x0_we", rf_we, 0);
    issue_valid = 1; issue_rd = 20; alu_valid = 1; alu_rd = 21;
    mem_valid = 1; mem_rd = 22; step(); mem_rd = 23; step();
    idle(); reset = 1; step(); reset = 0;
    chk("t5_rst_cnt", mq_count, 0); chk("t5_rst_we", rf_we, 0);
    for (int r = 1; r < 32; r++) begin rs1 = 5'(r); #1; chk("t5_busy0", rs1_busy, 0); end
    step(); chk("t5_no_write", rf_we, 0);

`ifdef WB_BYPASS_EN
    // 6. Forwarding on commit
    issue_valid = 1; issue_rd = 9; step();
    idle(); alu_valid = 1; alu_rd = 9; alu_data = 32'h1234; step();
    idle(); rs2 = 9; #1;
    chk("t6_hit", rs2_fwd_hit, 1); chk("t6_data", rs2_fwd_data, 32'h1234); chk("t6_busy", rs2_busy, 0);
    step();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      issue_valid = $urandom_range(0, 1);  issue_rd = 5'($urandom_range(0, 7));
      alu_valid   = ($urandom_range(0, 2) != 0); alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      mem_valid   = $urandom_range(0, 1);  mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      step();
    end
    reset = 0; idle();
    for (int i = 0; i < 10; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
